// File: rtl/ahb_pkg.sv
// Shared AHB-lite bus encodings and the slave transfer-state type.
// Both the SRAM slave and the CPU memory access unit use this package.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahb_state_e;

  // Byte-lane enables for a little-endian, lane-aligned transfer.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << off;
      HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Synchronous word array: one registered read port, one byte-enabled write port.
// On a same-edge read/write collision the read returns the pre-write word.
module sram_1rw_be #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  // Byte-lane write of the enabled lanes only.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read; output holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite slave wrapping a single-port data SRAM: programmable wait states,
// byte-lane writes, two-cycle ERROR for illegal accesses, and forwarding of a
// completing write into a read accepted at the same edge.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  ahb_state_e state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;

  logic                  accept_p0;
  logic                  legal_p0;
  logic [ADDR_WIDTH-1:0] idx_p0;
  logic [3:0]            be_p0;

  logic                  wr_p1;
  logic [ADDR_WIDTH-1:0] idx_p1;
  logic [3:0]            be_p1;
  logic                  commit_p1;
  logic [3:0]            fwd_be_p1;
  logic [31:0]           fwd_data_p1;
  logic [31:0]           sram_rdata_p1;
  logic [31:0]           rd_word_p1;

  // ---- address phase (p0) ----
  assign accept_p0 = HSEL & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ)) & HREADY;
  assign idx_p0    = HADDR[ADDR_WIDTH+1:2];
  assign be_p0     = byte_strobe(HSIZE, HADDR[1:0]);

  // Legality: size, natural alignment, and window membership (window is size-aligned).
  always_comb begin
    legal_p0 = 1'b1;
    if (HSIZE > HSIZE_WORD) legal_p0 = 1'b0;
    if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) legal_p0 = 1'b0;
    if ((HSIZE == HSIZE_HALF) && HADDR[0]) legal_p0 = 1'b0;
    if (HADDR[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2]) legal_p0 = 1'b0;
  end

  // Next transfer state; DATA and ERR2 chain straight into a new accept.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == 3'd0) state_d = ST_DATA;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (!accept_p0) begin
          state_d = ST_IDLE;
        end else if (!legal_p0) begin
          state_d = ST_ERR1;
        end else if (WAIT_STATES == 0) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_WAIT;
          wcnt_d  = WAIT_LOAD;
        end
      end
    endcase
  end

  // Control state with asynchronous reset; an in-flight transfer is simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // ---- data phase (p1) ----
  assign commit_p1 = (state_q == ST_DATA) & wr_p1;

  // Latch the accepted transfer; capture forwarding lanes when the completing
  // write targets the word this read is fetching.
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      wr_p1       <= HWRITE;
      idx_p1      <= idx_p0;
      be_p1       <= be_p0;
      fwd_be_p1   <= (commit_p1 && !HWRITE && (idx_p0 == idx_p1)) ? be_p1 : 4'b0000;
      fwd_data_p1 <= HWDATA;
    end
  end

  sram_1rw_be #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk  (clk),
    .re   (accept_p0 & ~HWRITE),
    .raddr(idx_p0),
    .rdata(sram_rdata_p1),
    .we   (commit_p1),
    .waddr(idx_p1),
    .be   (be_p1),
    .wdata(HWDATA)
  );

  // Merge forwarded write lanes over the word read from the array.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      rd_word_p1[8*b +: 8] = fwd_be_p1[b] ? fwd_data_p1[8*b +: 8] : sram_rdata_p1[8*b +: 8];
    end
  end

  assign HRDATA = (((state_q == ST_WAIT) || (state_q == ST_DATA)) && !wr_p1) ? rd_word_p1 : 32'd0;
  assign HREADY = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign HRESP  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (zero and one wait state) share one
// input stream; a transaction-level model predicts every output every cycle,
// and directed sequences pin literal expectations.
module tb_ahb_sram_slave;

  localparam int          AW    = 6;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        hsel  = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize  = 3'd2;
  logic [31:0] hwdata = 32'd0;

  logic [31:0] hrdata [2];
  logic        hready [2];
  logic [1:0]  hresp  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]));

  ahb_sram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]));

  // ---------------- transaction-level model ----------------
  bit          m_act  [2];
  bit          m_err  [2];
  bit          m_wr   [2];
  int          m_left [2];
  int          m_idx  [2];
  int          m_lo   [2];
  int          m_n    [2];
  logic [31:0] m_rval [2];
  logic [31:0] mem    [2][DEPTH];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  task automatic cmp(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  // A read accepted at an edge sees memory after that edge's completing write.
  task automatic model_step(input int d, input bit rdy);
    bit          complete, acc, bad;
    int          nb;
    longint      a;
    logic [31:0] w;
    complete = m_act[d] && rdy;
    if (complete && !m_err[d] && m_wr[d]) begin
      w = mem[d][m_idx[d]];
      for (int b = m_lo[d]; b < m_lo[d] + m_n[d]; b++) w[8*b +: 8] = hwdata[8*b +: 8];
      mem[d][m_idx[d]] = w;
    end
    acc = hsel && (htrans == 2'd2 || htrans == 2'd3) && rdy;
    if (acc) begin
      a   = longint'(haddr);
      nb  = (hsize <= 3'd2) ? (1 << hsize) : 0;
      bad = (nb == 0);
      if (!bad && (a % nb) != 0) bad = 1'b1;
      if (a < longint'(BASE) || a >= longint'(BASE) + 4 * DEPTH) bad = 1'b1;
      m_act[d]  = 1'b1;
      m_err[d]  = bad;
      m_left[d] = bad ? 1 : ws_of(d);
      m_wr[d]   = hwrite;
      if (!bad) begin
        m_idx[d]  = int'((a - longint'(BASE)) / 4);
        m_lo[d]   = int'(a % 4);
        m_n[d]    = nb;
        m_rval[d] = mem[d][m_idx[d]];
      end
    end else if (complete) begin
      m_act[d] = 1'b0;
    end else if (m_act[d]) begin
      m_left[d]--;
    end
  endtask

  // Compare every cycle at the falling edge, then step the model.
  initial begin
    bit          e_rdy;
    logic [1:0]  e_resp;
    logic [31:0] e_rd;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[d][i] = 32'd0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) m_act[d] = 1'b0;
        if (!m_act[d]) begin
          e_rdy = 1'b1; e_resp = 2'b00; e_rd = 32'd0;
        end else begin
          e_rdy  = (m_left[d] == 0);
          e_resp = m_err[d] ? 2'b01 : 2'b00;
          e_rd   = (m_err[d] || m_wr[d]) ? 32'd0 : m_rval[d];
        end
        cmp("model_hready", d, 32'(hready[d]), 32'(e_rdy));
        cmp("model_hresp",  d, 32'(hresp[d]),  32'(e_resp));
        cmp("model_hrdata", d, hrdata[d], e_rd);
        if (!reset) model_step(d, e_rdy);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic addr_phase(input logic w, input logic [2:0] sz, input logic [31:0] a);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = w; hsize = sz; haddr = a;
  endtask

  task automatic go_idle();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    addr_phase(1'b1, sz, a);
    @(posedge clk); #1;
    go_idle();
    hwdata = d;
    repeat (2) @(posedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_phase(1'b0, 3'd2, a);
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    chk({tag, "_ws0_data"},  hrdata[0], exp);
    chk({tag, "_ws0_ready"}, 32'(hready[0]), 32'd1);
    chk({tag, "_ws1_stall"}, 32'(hready[1]), 32'd0);
    @(negedge clk);
    chk({tag, "_ws1_data"},  hrdata[1], exp);
    chk({tag, "_ws1_ready"}, 32'(hready[1]), 32'd1);
    chk({tag, "_ws1_resp"},  32'(hresp[1]), 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic [31:0] a);
    addr_phase(1'b0, 3'd2, a);
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    chk({tag, "_err1_ready"}, 32'(hready[1]), 32'd0);
    chk({tag, "_err1_resp"},  32'(hresp[1]),  32'd1);
    chk({tag, "_err1_ready0"}, 32'(hready[0]), 32'd0);
    @(negedge clk);
    chk({tag, "_err2_ready"}, 32'(hready[1]), 32'd1);
    chk({tag, "_err2_resp"},  32'(hresp[1]),  32'd1);
    @(negedge clk);
    chk({tag, "_after_resp"}, 32'(hresp[1]), 32'd0);
    chk({tag, "_after_resp0"}, 32'(hresp[0]), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_hready", 32'(hready[d]), 32'd1);
      chk("reset_hresp",  32'(hresp[d]),  32'd0);
      chk("reset_hrdata", hrdata[d],      32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) wr(3'd2, BASE + 32'(4 * i), 32'd0);

    // word write then read
    wr(3'd2, 32'h10, 32'hDEAD_BEEF);
    rd_chk("t1_read", 32'h10, 32'hDEAD_BEEF);

    // single byte on lane 2 over an existing word
    wr(3'd2, 32'h10, 32'h1122_3344);
    wr(3'd0, 32'h12, 32'h77A5_9911);
    rd_chk("t2_byte", 32'h10, 32'h11A5_3344);

    // misaligned word read, then a legal read of untouched memory
    err_chk("t3_misalign", 32'h02);
    rd_chk("t3_follow", 32'h00, 32'h0000_0000);

    // one past the window, then IDLE with HSEL high
    err_chk("t5_range", BASE + 32'(4 * DEPTH));
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b00; haddr = 32'h40;
    @(negedge clk);
    chk("t5_idle_ready", 32'(hready[1]), 32'd1);
    chk("t5_idle_resp",  32'(hresp[1]),  32'd0);
    chk("t5_idle_rdata", hrdata[1],      32'd0);
    @(posedge clk); #1;
    go_idle();

    // back-to-back halfword write then word read of the same word
    addr_phase(1'b1, 3'd1, 32'h20);
    @(posedge clk); #1;
    hwrite = 1'b0; hsize = 3'd2; haddr = 32'h20; hwdata = 32'hCAFE_BEEF;
    @(negedge clk);
    chk("t4_no_stall", 32'(hready[0]), 32'd1);
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    chk("t4_fwd_data",  hrdata[0], 32'h0000_BEEF);
    chk("t4_fwd_ready", 32'(hready[0]), 32'd1);
    repeat (3) @(posedge clk);
    rd_chk("t4_after", 32'h20, 32'h0000_BEEF);

    // reset in the middle of a write
    addr_phase(1'b1, 3'd2, 32'h30);
    @(posedge clk); #1;
    go_idle();
    hwdata = 32'hFFFF_FFFF;
    reset  = 1'b1;
    #1;
    chk("t6_rst_ready", 32'(hready[1]), 32'd1);
    chk("t6_rst_resp",  32'(hresp[1]),  32'd0);
    chk("t6_rst_rdata", hrdata[1],      32'd0);
    chk("t6_rst_ready0", 32'(hready[0]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    rd_chk("t6_no_write", 32'h30, 32'h0000_0000);

    // randomized traffic over a small set of words, with occasional faults and resets
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk); #1;
      reset  = ($urandom_range(0, 199) == 0);
      hsel   = ($urandom_range(0, 3) != 0);
      htrans = 2'($urandom_range(0, 3));
      hwrite = 1'($urandom_range(0, 1));
      r      = $urandom_range(0, 9);
      hsize  = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      if ($urandom_range(0, 9) == 0) haddr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 31));
      else                           haddr = BASE + 32'($urandom_range(0, 63));
      hwdata = $urandom;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    go_idle();
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- Single-port on-chip data SRAM that acts as an AHB-lite slave. It sits directly downstream of the CPU memory access unit on the simplified AHB bus.
- Consumes address-phase signals (HADDR, HTRANS, HWRITE, HSIZE) and the data-phase HWDATA. Returns HRDATA, HREADY and HRESP.
- Provides programmable wait states, byte-lane writes, error responses for illegal accesses, and read-after-write forwarding for back-to-back transfers.

Parameters:
- ADDR_WIDTH, 12, word-index bits; capacity = 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window; must be aligned to the window size.
- WAIT_STATES, 1, extra HREADY-low cycles per OKAY data phase; legal range 0..7.

Ports:
- clk  in  1  system clock; the bus clock is the same net.
- reset  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address, address phase.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HWDATA  in  32  write data, data phase, lane-aligned by the master.
- HRDATA  out  32  read data, full word; the master extracts the lanes.
- HREADY  out  1  transfer-complete; also used as HREADYin (single-slave bus).
- HRESP  out  2  OKAY=00, ERROR=01; RETRY and SPLIT are never issued.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; HREADY=1, HRESP=OKAY, HRDATA=0.
  - Pending write is discarded. SRAM contents are not cleared.
  - Reset mid data phase aborts the transfer; no partial write.
- Address-phase accept condition: HSEL & HTRANS[1] & HREADY at a rising edge. On accept, latch HADDR, HWRITE and HSIZE.
  - IDLE and BUSY transfers are never latched. They get a zero-wait OKAY (HREADY stays 1).
- Legality check at accept. The transfer is illegal if any of the following holds:
  - HSIZE > 010;
  - word access with addr[1:0] != 0;
  - halfword access with addr[0] != 0;
  - address outside [BASE_ADDR, BASE_ADDR + 4*2^ADDR_WIDTH).
- States:
  - IDLE -> WAIT (legal, WAIT_STATES>0) | DATA (legal, WAIT_STATES=0) | ERR1 (illegal).
  - WAIT: HREADY=0, HRESP=OKAY. A 3-bit counter loads WAIT_STATES-1 and decrements; goes to DATA when it reaches 0.
  - DATA: HREADY=1, HRESP=OKAY. This is the completion cycle. Next state is evaluated exactly as from IDLE, which gives back-to-back pipelining: a new accept in the DATA cycle is legal.
  - ERR1: HREADY=0, HRESP=ERROR -> ERR2.
  - ERR2: HREADY=1, HRESP=ERROR. Next state is evaluated exactly as from IDLE. No SRAM write occurs for an errored transfer.
- Reads:
  - The SRAM word is read at the accept edge and registered.
  - HRDATA presents the registered word during WAIT and DATA of a read; HRDATA=0 otherwise.
  - Latency from accept to completion = 1 + WAIT_STATES cycles.
- Writes:
  - Byte strobes are derived from the latched size and addr[1:0]:
    - byte -> one lane;
    - half -> lanes 1:0 or 3:2;
    - word -> all lanes.
  - The SRAM is written with HWDATA lanes at the DATA-cycle edge (HREADY=1).
  - HWDATA is ignored in WAIT cycles.
- Read-after-write forwarding: if a read is accepted at the same edge that commits a write to the same word index, the registered read word merges the strobed HWDATA lanes over the old SRAM word.
- HRESP returns to OKAY in the cycle after ERR2 unless a new illegal transfer was accepted at that edge.

Decomposition:
- Shared package `ahb_pkg` holds:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ;
  - HRESP codes OKAY/ERROR/RETRY/SPLIT;
  - HSIZE codes;
  - a state enum for IDLE/WAIT/DATA/ERR1/ERR2.
  - The MAU consumes the same package.
- One sub-module, `sram_1rw_be`: a synchronous 1-read/1-write word array with 4-bit byte enables and registered read. Forwarding logic stays in the parent.

Test Plan:
1. Reset, then word write 32'hDEADBEEF to 0x10, then word read 0x10 (WAIT_STATES=1) -> one HREADY=0 cycle, then HRDATA=32'hDEADBEEF, HRESP=OKAY.
2. Byte write 8'hA5 on lane 2 to 0x12 over word 0x11223344, then word read 0x10 -> 32'h11A53344.
3. Word read at 0x02 -> ERR1 (HREADY=0, HRESP=01), then ERR2 (HREADY=1, HRESP=01). A following legal read of 0x00 gets OKAY. SRAM is unchanged.
4. WAIT_STATES=0, back-to-back: halfword write 16'hBEEF to 0x20, immediately followed by word read of 0x20 (old content 0) -> read returns 32'h0000BEEF with no stall cycles.
5. Address BASE_ADDR + 4*2^ADDR_WIDTH -> two-cycle ERROR response. HTRANS=IDLE with HSEL=1 -> HREADY=1, OKAY, no state change.
6. Assert reset during WAIT of a write to 0x30 holding 0x0 -> HREADY=1, HRESP=OKAY, HRDATA=0 immediately. A subsequent read of 0x30 returns 0.
